// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: row-scan scheduler for a 7x5 LED matrix.
// Holds a double-buffered frame, lights one row at a time for DWELL cycles
// with a BLANK-cycle all-off gap before each row, and swaps front/back
// buffers only at a frame boundary so a torn frame is never shown.
//
// Ports:
//   clk_div    scan clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   en         scan enable (level); low forces OFF on the next cycle
//   wr_en      write strobe into the back buffer
//   wr_row     target row of the write (>= ROWS ignored)
//   wr_data    column pattern for wr_row
//   swap_req   level request to exchange buffers at the next frame boundary
//   swap_ack   one-cycle pulse in the cycle the swap took effect
//   row_n      active-low row drive, at most one bit low
//   col        active-high column drive
//   row_idx    row currently scheduled
//   frame_done one-cycle pulse at each frame wrap
module matrix_scan_ctrl #(
    parameter int unsigned ROWS  = 7,
    parameter int unsigned COLS  = 5,
    parameter int unsigned DWELL = 8,
    parameter int unsigned BLANK = 1
) (
    input  logic            clk_div,
    input  logic            rst_n,
    input  logic            en,
    input  logic            wr_en,
    input  logic [2:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap_req,
    output logic            swap_ack,
    output logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col,
    output logic [2:0]      row_idx,
    output logic            frame_done
);

    localparam int unsigned CNT_MAX    = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned DWELL_LAST = DWELL - 1;
    localparam int unsigned BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       row_d;
    logic             front_sel, sel_d;
    logic             back_sel;
    logic             swap_ack_d, frame_done_d;
    logic [ROWS-1:0]  row_n_d;
    logic [COLS-1:0]  col_d;
    logic [COLS-1:0]  show_data;
    logic             wr_hit;

    logic [COLS-1:0]  fb [2][ROWS];

    assign back_sel = ~front_sel;
    assign wr_hit   = wr_en && (32'(wr_row) < ROWS);

    // State and registered outputs
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            cnt        <= '0;
            row_idx    <= '0;
            front_sel  <= 1'b0;
            swap_ack   <= 1'b0;
            frame_done <= 1'b0;
            row_n      <= '1;
            col        <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            row_idx    <= row_d;
            front_sel  <= sel_d;
            swap_ack   <= swap_ack_d;
            frame_done <= frame_done_d;
            row_n      <= row_n_d;
            col        <= col_d;
        end
    end

    // Back-buffer writes; the front buffer is never written
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            fb <= '{default: '0};
        end else if (wr_hit) begin
            fb[back_sel][wr_row] <= wr_data;
        end
    end

    // Next state, row sequencing and boundary swap
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        row_d        = row_idx;
        sel_d        = front_sel;
        swap_ack_d   = 1'b0;
        frame_done_d = 1'b0;

        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            row_d   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = (BLANK == 0) ? ST_SHOW : ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt == CNT_W'(BLANK_LAST)) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt == CNT_W'(DWELL_LAST)) begin
                        cnt_d   = '0;
                        state_d = (BLANK == 0) ? ST_SHOW : ST_BLANK;
                        if (row_idx == 3'(ROWS - 1)) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            if (swap_req) begin
                                sel_d      = ~front_sel;
                                swap_ack_d = 1'b1;
                            end
                        end else begin
                            row_d = row_idx + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            endcase
        end
    end

    // Row data for the next cycle; on a swap edge the new front is the old
    // back, including a write landing on that same edge
    always_comb begin
        show_data = fb[front_sel][row_d];
        if (sel_d != front_sel) begin
            if (wr_hit && (wr_row == row_d)) begin
                show_data = wr_data;
            end else begin
                show_data = fb[back_sel][row_d];
            end
        end
    end

    // Drive values registered alongside the state
    always_comb begin
        row_n_d = '1;
        col_d   = '0;
        if (state_d == ST_SHOW) begin
            row_n_d = ~(ROWS'(1) << row_d);
            col_d   = show_data;
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: stimulus pushes expected row runs
// and frame boundaries; negedge monitors pop and compare as the DUT shows them.
module tb_matrix_scan_ctrl;

    logic       clk_div = 1'b0;
    logic       rst_n;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [4:0] wr_data;
    logic       swap_req;

    logic       swap_ack, frame_done;
    logic [6:0] row_n;
    logic [4:0] col;
    logic [2:0] row_idx;

    logic       nb_swap_ack, nb_frame_done;
    logic [6:0] nb_row_n;
    logic [4:0] nb_col;
    logic [2:0] nb_row_idx;

    always #5 clk_div = ~clk_div;

    matrix_scan_ctrl u_dut (
        .clk_div    (clk_div),
        .rst_n      (rst_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .row_n      (row_n),
        .col        (col),
        .row_idx    (row_idx),
        .frame_done (frame_done)
    );

    matrix_scan_ctrl #(.BLANK(0)) u_nb (
        .clk_div    (clk_div),
        .rst_n      (rst_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (nb_swap_ack),
        .row_n      (nb_row_n),
        .col        (nb_col),
        .row_idx    (nb_row_idx),
        .frame_done (nb_frame_done)
    );

    typedef struct packed {
        logic [2:0] row;
        logic [4:0] col;
        logic [7:0] len;
    } run_t;

    run_t rq[$];
    bit   bq[$];

    int n_chk = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_div);
        #1;
    endtask

    task automatic push_row(input int r, input logic [4:0] c, input int len);
        run_t e;
        e.row = 3'(r);
        e.col = c;
        e.len = 8'(len);
        rq.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0][4:0] f, input bit swap);
        for (int r = 0; r < 7; r++) push_row(r, f[r], 8);
        bq.push_back(swap);
    endtask

    function automatic int lit_row(input logic [6:0] rn);
        for (int i = 0; i < 7; i++) if (!rn[i]) return i;
        return -1;
    endfunction

    // Main DUT monitor: row runs, blanking, boundary pulses
    int         run_on = 0;
    logic [2:0] run_row;
    logic [4:0] run_col;
    int         run_len;
    int         mr;
    bit         bexp;
    run_t       ce;

    task automatic close_run();
        check(rq.size() != 0, "run_queue", int'(run_row), -1);
        if (rq.size() != 0) begin
            ce = rq.pop_front();
            check(run_row == ce.row, "run_row", int'(run_row), int'(ce.row));
            check(run_col == ce.col, "run_col", int'(run_col), int'(ce.col));
            check(run_len == int'(ce.len), "run_len", run_len, int'(ce.len));
        end
    endtask

    always @(negedge clk_div) begin
        if (!rst_n || !mon_on) begin
            run_on = 0;
        end else begin
            if (row_n == 7'h7F) begin
                check(col == 5'h00, "blank_col", int'(col), 0);
                if (run_on != 0) close_run();
                run_on = 0;
            end else begin
                mr = lit_row(row_n);
                check($countones(row_n) == 6, "one_row_low", int'(row_n), 6);
                check(int'(row_idx) == mr, "lit_row_idx", int'(row_idx), mr);
                if (run_on != 0 && 3'(mr) == run_row) begin
                    run_len++;
                    check(col == run_col, "col_stable", int'(col), int'(run_col));
                end else begin
                    if (run_on != 0) close_run();
                    run_on  = 1;
                    run_row = 3'(mr);
                    run_col = col;
                    run_len = 1;
                end
            end
            if (frame_done) begin
                check(bq.size() != 0, "boundary_queue", 1, 0);
                if (bq.size() != 0) begin
                    bexp = bq.pop_front();
                    check(swap_ack == bexp, "swap_ack", int'(swap_ack), int'(bexp));
                end
                check(row_idx == 3'd0, "wrap_row_idx", int'(row_idx), 0);
            end else begin
                check(!swap_ack, "stray_swap_ack", int'(swap_ack), 0);
            end
        end
    end

    // BLANK=0 instance: always lit while enabled, DWELL-long runs in row order
    logic       en_q;
    int         nb_on = 0;
    logic [2:0] nb_row;
    int         nb_len;
    int         nr;

    always @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= en;
    end

    always @(negedge clk_div) begin
        if (rst_n && en_q) check(nb_row_n != 7'h7F, "nb_lit", int'(nb_row_n), 0);
        if (!rst_n || nb_row_n == 7'h7F) begin
            nb_on = 0;
        end else begin
            nr = lit_row(nb_row_n);
            if (nb_on != 0 && 3'(nr) == nb_row) begin
                nb_len++;
            end else begin
                if (nb_on != 0) begin
                    check(nb_len == 8, "nb_dwell", nb_len, 8);
                    check(nr == (int'(nb_row) + 1) % 7, "nb_order", nr, (int'(nb_row) + 1) % 7);
                end
                nb_on  = 1;
                nb_row = 3'(nr);
                nb_len = 1;
            end
        end
    end

    logic [6:0][4:0] pat, zero, z3, za;

    initial begin
        pat[0] = 5'h01; pat[1] = 5'h02; pat[2] = 5'h04; pat[3] = 5'h08;
        pat[4] = 5'h10; pat[5] = 5'h1F; pat[6] = 5'h15;
        zero   = '0;
        z3     = '0;
        z3[3]  = 5'h1F;
        za     = z3;
        za[0]  = 5'h0A;

        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;
        step(3);
        rst_n = 1'b1;
        check(row_n == 7'h7F, "rst_row_n", int'(row_n), 'h7F);
        check(col == 5'h00, "rst_col", int'(col), 0);
        check(row_idx == 3'd0, "rst_row_idx", int'(row_idx), 0);
        check(!swap_ack, "rst_swap_ack", int'(swap_ack), 0);
        check(!frame_done, "rst_frame_done", int'(frame_done), 0);

        // Asynchronous reset while row 1 is lit
        en = 1'b1;
        step(12);
        check(row_idx == 3'd1, "pre_rst_row_idx", int'(row_idx), 1);
        check(row_n == 7'b1111101, "pre_rst_row_n", int'(row_n), 'h7D);
        #2 rst_n = 1'b0;
        #1;
        check(row_n == 7'h7F, "async_row_n", int'(row_n), 'h7F);
        check(col == 5'h00, "async_col", int'(col), 0);
        check(row_idx == 3'd0, "async_row_idx", int'(row_idx), 0);
        check(!swap_ack, "async_swap_ack", int'(swap_ack), 0);
        check(!frame_done, "async_frame_done", int'(frame_done), 0);
        #2 en = 1'b0;
        rst_n = 1'b1;
        step(2);

        // Load back buffer, swap at first boundary
        for (int r = 0; r < 7; r++) begin
            wr_en = 1'b1; wr_row = 3'(r); wr_data = pat[r];
            step(1);
        end
        wr_en  = 1'b0;
        mon_on = 1'b1;
        push_frame(zero, 1'b1);
        push_frame(pat, 1'b0);
        en = 1'b1; swap_req = 1'b1;
        step(64);
        swap_req = 1'b0;

        // Out-of-range and row 3 writes into the back buffer
        wr_en = 1'b1; wr_row = 3'd7; wr_data = 5'h1F;
        step(1);
        wr_row = 3'd3;
        step(1);
        wr_en = 1'b0;
        step(61);

        // Deferred swap raised mid-frame
        push_frame(pat, 1'b1);
        step(19);
        swap_req = 1'b1;
        step(44);
        swap_req = 1'b0;

        // Abort during row 4 with swap pending
        for (int r = 0; r < 4; r++) push_row(r, z3[r], 8);
        push_row(4, z3[4], 3);
        step(39);
        en = 1'b0; swap_req = 1'b1;
        step(1);
        check(row_n == 7'h7F, "abort_row_n", int'(row_n), 'h7F);
        check(row_idx == 3'd0, "abort_row_idx", int'(row_idx), 0);
        check(!frame_done, "abort_frame_done", int'(frame_done), 0);
        step(3);

        // Restart from row 0 with old front; pending swap at next boundary
        push_frame(z3, 1'b1);
        push_frame(pat, 1'b1);
        en = 1'b1;
        step(64);
        swap_req = 1'b0;

        // Write and swap on the same boundary-entry edge
        step(62);
        wr_en = 1'b1; wr_row = 3'd0; wr_data = 5'h0A; swap_req = 1'b1;
        step(1);
        wr_en = 1'b0; swap_req = 1'b0;
        push_frame(za, 1'b0);
        step(63);
        en = 1'b0;
        step(3);

        check(rq.size() == 0, "rows_left", rq.size(), 0);
        check(bq.size() == 0, "boundaries_left", bq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
